// File: rtl/rr_busarbiter.sv
// rr_busarbiter: round-robin arbiter that funnels single-beat load/store
// requests from NCORES cores onto one downstream bus port.
//
// Ports
//   CLK, RST_X            clock (rising edge) and asynchronous active-low reset
//   init_done             enables new arbitration decisions
//   req_le/req_we         per-core one-cycle load/store strobes
//   req_lock              per-core atomic hold request
//   req_addr/wdata/ctrl   per-core request payload, core i at slice i
//   core_busy             per-core transaction outstanding
//   core_rdata            per-core last returned read data
//   m_le/m_we/m_addr/m_wdata/m_ctrl  downstream request
//   m_busy/m_rdata        downstream handshake and read data
//   grant                 index of the currently granted core
//   locked                grant is held for an atomic sequence
//   err                   sticky protocol error flag
module rr_busarbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int IW     = $clog2(NCORES)
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 init_done,
    input  logic [NCORES-1:0]    req_le,
    input  logic [NCORES-1:0]    req_we,
    input  logic [NCORES-1:0]    req_lock,
    input  logic [NCORES*AW-1:0] req_addr,
    input  logic [NCORES*DW-1:0] req_wdata,
    input  logic [NCORES*3-1:0]  req_ctrl,
    output logic [NCORES-1:0]    core_busy,
    output logic [NCORES*DW-1:0] core_rdata,
    output logic                 m_le,
    output logic                 m_we,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    output logic [2:0]           m_ctrl,
    input  logic                 m_busy,
    input  logic [DW-1:0]        m_rdata,
    output logic [IW-1:0]        grant,
    output logic                 locked,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_r, state_next_s;
    logic [NCORES-1:0]     pend_r;
    logic [NCORES-1:0]     strobe_s, cap_s, clr_s;
    logic [NCORES*AW-1:0]  slot_addr_r;
    logic [NCORES*DW-1:0]  slot_wdata_r;
    logic [NCORES*3-1:0]   slot_ctrl_r;
    logic [NCORES-1:0]     slot_le_r, slot_we_r;
    logic [IW-1:0]         grant_r, winner_s, idx_s;
    logic                  found_s, select_s, complete_s, idle_err_s, dup_err_s;
    logic                  locked_r, err_r, m_le_r, m_we_r;
    logic [AW-1:0]         m_addr_r;
    logic [DW-1:0]         m_wdata_r;
    logic [2:0]            m_ctrl_r;
    logic [NCORES*DW-1:0]  core_rdata_r;

    // A strobe is captured only into an empty slot; a strobe into a full slot is a protocol error.
    assign strobe_s  = req_le | req_we;
    assign cap_s     = strobe_s & ~pend_r;
    assign dup_err_s = |(strobe_s & pend_r);

    // Winner search: scanning from grant+NCORES down to grant+1 lets the nearest pending index win; grant itself is last.
    always_comb begin
        idx_s    = '0;
        winner_s = grant_r;
        found_s  = 1'b0;
        if (locked_r) begin
            found_s = pend_r[grant_r];
        end else begin
            for (int k = NCORES; k >= 1; k--) begin
                idx_s    = IW'((int'(grant_r) + k) % NCORES);
                winner_s = pend_r[idx_s] ? idx_s : winner_s;
            end
            found_s = |pend_r;
        end
    end

    // Next-state and control strobes of the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        state_next_s = state_r;
        select_s     = 1'b0;
        complete_s   = 1'b0;
        idle_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (m_busy) begin
                    idle_err_s = 1'b1;
                end else if (init_done && found_s) begin
                    select_s     = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_busy) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (!m_busy) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // One-hot clear of the granted core's pending bit on completion.
    always_comb begin
        clr_s = '0;
        if (complete_s) begin
            clr_s[grant_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-core request slots and pending flags.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            pend_r       <= '0;
            slot_addr_r  <= '0;
            slot_wdata_r <= '0;
            slot_ctrl_r  <= '0;
            slot_le_r    <= '0;
            slot_we_r    <= '0;
        end else begin
            pend_r <= (pend_r | cap_s) & ~clr_s;
            for (int i = 0; i < NCORES; i++) begin
                if (cap_s[i]) begin
                    slot_addr_r[i*AW +: AW]  <= req_addr[i*AW +: AW];
                    slot_wdata_r[i*DW +: DW] <= req_wdata[i*DW +: DW];
                    slot_ctrl_r[i*3 +: 3]    <= req_ctrl[i*3 +: 3];
                    slot_le_r[i]             <= req_le[i];
                    slot_we_r[i]             <= req_we[i];
                end
            end
        end
    end

    // Downstream request registers, grant index and lock flag.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            grant_r   <= '0;
            locked_r  <= 1'b0;
            m_le_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            m_ctrl_r  <= 3'd0;
        end else begin
            if (select_s) begin
                grant_r   <= winner_s;
                m_le_r    <= slot_le_r[winner_s];
                m_we_r    <= slot_we_r[winner_s];
                m_addr_r  <= slot_addr_r[int'(winner_s)*AW +: AW];
                m_wdata_r <= slot_wdata_r[int'(winner_s)*DW +: DW];
                m_ctrl_r  <= slot_ctrl_r[int'(winner_s)*3 +: 3];
            end else if (state_r == ST_ISSUE && m_busy) begin
                m_le_r <= 1'b0;
                m_we_r <= 1'b0;
            end
            // Lock follows the winner at selection; otherwise any IDLE edge without the holder's lock releases it.
            if (state_r == ST_IDLE) begin
                if (select_s) begin
                    locked_r <= req_lock[winner_s];
                end else if (!req_lock[grant_r]) begin
                    locked_r <= 1'b0;
                end
            end
        end
    end

    // Returned data per core and the sticky error flag.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            core_rdata_r <= '0;
            err_r        <= 1'b0;
        end else begin
            if (complete_s) begin
                core_rdata_r[int'(grant_r)*DW +: DW] <= m_rdata;
            end
            if (dup_err_s || idle_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign core_busy  = pend_r;
    assign core_rdata = core_rdata_r;
    assign m_le       = m_le_r;
    assign m_we       = m_we_r;
    assign m_addr     = m_addr_r;
    assign m_wdata    = m_wdata_r;
    assign m_ctrl     = m_ctrl_r;
    assign grant      = grant_r;
    assign locked     = locked_r;
    assign err        = err_r;

endmodule

// File: tb/tb_rr_busarbiter.sv
// Testbench for rr_busarbiter: a behavioural downstream slave logs every issued
// transaction, and each test task compares the log and DUT outputs against
// expectations derived from the arbitration rules.
module tb_rr_busarbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            CLK = 1'b0;
    logic            RST_X = 1'b0;
    logic            init_done = 1'b0;
    logic [N-1:0]    req_le = '0, req_we = '0, req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*3-1:0]  req_ctrl = '0;
    logic [N-1:0]    core_busy;
    logic [N*DW-1:0] core_rdata;
    logic            m_le, m_we, m_busy, locked, err;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [2:0]      m_ctrl;
    logic [IW-1:0]   grant;

    int checks = 0;
    int fails  = 0;
    int model_grant = 0;

    typedef struct {
        int            core;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    ctrl;
        logic          le;
        logic          we;
        logic [DW-1:0] rd;
    } txn_t;
    txn_t log_q[$];

    int            slv_dly_min = 0, slv_dly_max = 0, slv_bl_min = 1, slv_bl_max = 1;
    logic          slv_fix_en = 1'b0;
    logic [DW-1:0] slv_fix_rd = '0;
    logic          poke_busy = 1'b0;

    rr_busarbiter #(.NCORES(N), .AW(AW), .DW(DW), .IW(IW)) dut (
        .CLK(CLK), .RST_X(RST_X), .init_done(init_done),
        .req_le(req_le), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
        .core_busy(core_busy), .core_rdata(core_rdata),
        .m_le(m_le), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ctrl(m_ctrl),
        .m_busy(m_busy), .m_rdata(m_rdata),
        .grant(grant), .locked(locked), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Downstream slave: acts 2 time units after each edge so it sees bench writes made at +1.
    initial begin : slave
        txn_t t;
        int   dly, bl;
        m_busy  = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge CLK); #2;
            if (RST_X && (m_le || m_we)) begin
                t.core  = int'(grant);
                t.addr  = m_addr;
                t.wdata = m_wdata;
                t.ctrl  = m_ctrl;
                t.le    = m_le;
                t.we    = m_we;
                t.rd    = slv_fix_en ? slv_fix_rd : $urandom;
                log_q.push_back(t);
                dly = $urandom_range(slv_dly_max, slv_dly_min);
                bl  = $urandom_range(slv_bl_max, slv_bl_min);
                for (int c = 0; c < dly && RST_X; c++) begin
                    @(posedge CLK); #2;
                end
                m_busy = RST_X;
                for (int c = 0; c < bl && RST_X; c++) begin
                    @(posedge CLK); #2;
                end
                m_busy  = 1'b0;
                m_rdata = t.rd;
            end else begin
                m_busy = poke_busy;
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic set_req(input int c, input logic le, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] ct);
        req_le[c] = le;
        req_we[c] = we;
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*DW +: DW] = d;
        req_ctrl[c*3 +: 3]    = ct;
    endtask

    task automatic clr_req();
        req_le = '0;
        req_we = '0;
    endtask

    task automatic wait_clear(input logic [N-1:0] mask, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if ((core_busy & mask) == '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        #3 RST_X = 1'b0;
        tick();
        tick();
        #3 RST_X = 1'b1;
        tick();
        log_q.delete();
    endtask

    task automatic test_reset();
        #3;
        checks++; if (core_busy !== 4'b0 || core_rdata !== '0) begin fails++; $display("FAIL reset_core: busy=%h rdata=%h want 0", core_busy, core_rdata); end
        checks++; if ({m_le, m_we, locked, err} !== 4'b0) begin fails++; $display("FAIL reset_flags: le/we/lock/err=%b want 0000", {m_le, m_we, locked, err}); end
        checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_ctrl !== 3'd0 || grant !== 2'd0) begin fails++; $display("FAIL reset_bus: addr=%h wdata=%h ctrl=%h grant=%0d want 0", m_addr, m_wdata, m_ctrl, grant); end
        tick();
        #3 RST_X = 1'b1;
        init_done = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_rr[4] = '{1, 2, 3, 0};
        bit ok;
        for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, 32'h1000 + 32'(c), 32'h0, 3'd2);
        tick();
        clr_req();
        wait_clear(4'hF, 200, ok);
        checks++; if (!ok) begin fails++; $display("FAIL rr_timeout: busy=%b want 0000", core_busy); end
        checks++; if (log_q.size() !== 4) begin fails++; $display("FAIL rr_count: got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++; if (log_q[i].core !== exp_rr[i] || log_q[i].addr !== 32'h1000 + 32'(exp_rr[i])) begin fails++; $display("FAIL rr_order[%0d]: core=%0d addr=%h want core=%0d", i, log_q[i].core, log_q[i].addr, exp_rr[i]); end
        end
        log_q.delete();
    endtask

    task automatic test_single_load();
        bit ok;
        slv_fix_en = 1'b1;
        slv_fix_rd = 32'hDEADBEEF;
        set_req(2, 1'b1, 1'b0, 32'h100, 32'h0, 3'd2);
        tick();
        clr_req();
        checks++; if (m_le !== 1'b0 || core_busy[2] !== 1'b1) begin fails++; $display("FAIL single_c1: m_le=%b busy2=%b want 0 1", m_le, core_busy[2]); end
        tick();
        checks++; if (m_le !== 1'b1 || grant !== 2'd2 || m_addr !== 32'h100) begin fails++; $display("FAIL single_c2: m_le=%b grant=%0d addr=%h want 1 2 100", m_le, grant, m_addr); end
        tick();
        checks++; if (m_le !== 1'b0) begin fails++; $display("FAIL single_c3: m_le=%b want 0", m_le); end
        tick();
        checks++; if (core_busy[2] !== 1'b0 || core_rdata[2*DW +: DW] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_done: busy2=%b rdata2=%h want 0 deadbeef", core_busy[2], core_rdata[2*DW +: DW]); end
        slv_fix_en = 1'b0;
        log_q.delete();
        set_req(0, 1'b0, 1'b1, 32'h104, 32'h5555_AAAA, 3'd1);
        tick();
        clr_req();
        wait_clear(4'h1, 50, ok);
        checks++; if (!ok || log_q.size() != 1) begin fails++; $display("FAIL store0: done=%0b log=%0d want 1 1", ok, log_q.size()); end
        else begin
            checks++; if (core_rdata[0 +: DW] !== log_q[0].rd || core_rdata[2*DW +: DW] !== 32'hDEADBEEF) begin fails++; $display("FAIL rdata_hold: r0=%h r2=%h want %h deadbeef", core_rdata[0 +: DW], core_rdata[2*DW +: DW], log_q[0].rd); end
        end
        model_grant = 0;
        log_q.delete();
    endtask

    task automatic test_random();
        logic [AW-1:0] e_addr[N];
        logic [DW-1:0] e_wdata[N];
        logic [2:0]    e_ctrl[N];
        logic          e_le[N];
        int            order[$];
        logic [N-1:0]  mask, left;
        bit            ok;
        slv_dly_min = 0; slv_dly_max = 2; slv_bl_min = 1; slv_bl_max = 3;
        for (int b = 0; b < 20; b++) begin
            mask = 4'($urandom_range(15, 1));
            for (int c = 0; c < N; c++) begin
                e_addr[c]  = $urandom;
                e_wdata[c] = $urandom;
                e_ctrl[c]  = 3'($urandom);
                e_le[c]    = 1'($urandom);
                if (mask[c]) set_req(c, e_le[c], !e_le[c], e_addr[c], e_wdata[c], e_ctrl[c]);
            end
            tick();
            clr_req();
            order.delete();
            left = mask;
            while (left != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (left[(model_grant + k) % N]) begin
                        model_grant = (model_grant + k) % N;
                        order.push_back(model_grant);
                        left[model_grant] = 1'b0;
                        break;
                    end
                end
            end
            wait_clear(4'hF, 300, ok);
            checks++; if (!ok || log_q.size() != order.size()) begin fails++; $display("FAIL rand_count[%0d]: done=%0b got %0d want %0d", b, ok, log_q.size(), order.size()); end
            for (int i = 0; i < order.size() && i < log_q.size(); i++) begin
                checks++;
                if (log_q[i].core !== order[i] || log_q[i].addr !== e_addr[order[i]] || log_q[i].wdata !== e_wdata[order[i]] ||
                    log_q[i].ctrl !== e_ctrl[order[i]] || log_q[i].le !== e_le[order[i]] || log_q[i].we !== !e_le[order[i]]) begin
                    fails++; $display("FAIL rand_txn[%0d.%0d]: core=%0d addr=%h le=%b we=%b want core=%0d addr=%h le=%b", b, i, log_q[i].core, log_q[i].addr, log_q[i].le, log_q[i].we, order[i], e_addr[order[i]], e_le[order[i]]);
                end
                checks++; if (core_rdata[order[i]*DW +: DW] !== log_q[i].rd) begin fails++; $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", b, i, core_rdata[order[i]*DW +: DW], log_q[i].rd); end
            end
            checks++; if (err !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL rand_flags[%0d]: err=%b locked=%b want 0 0", b, err, locked); end
            log_q.delete();
        end
        slv_dly_max = 0; slv_bl_max = 1;
    endtask

    task automatic test_lock();
        bit ok;
        req_lock[1] = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'd2);
        tick();
        clr_req();
        tick();
        checks++; if (locked !== 1'b1 || grant !== 2'd1) begin fails++; $display("FAIL lock_set: locked=%b grant=%0d want 1 1", locked, grant); end
        set_req(3, 1'b0, 1'b1, 32'h300, 32'h33, 3'd0);
        tick();
        clr_req();
        wait_clear(4'h2, 50, ok);
        checks++; if (!ok || core_busy[3] !== 1'b1) begin fails++; $display("FAIL lock_first: done=%0b busy3=%b want 1 1", ok, core_busy[3]); end
        set_req(1, 1'b1, 1'b0, 32'h204, 32'h0, 3'd2);
        tick();
        clr_req();
        wait_clear(4'h2, 50, ok);
        checks++; if (!ok || locked !== 1'b1 || core_busy[3] !== 1'b1) begin fails++; $display("FAIL lock_second: done=%0b locked=%b busy3=%b want 1 1 1", ok, locked, core_busy[3]); end
        checks++; if (log_q.size() != 2 || log_q[0].addr !== 32'h200 || log_q[1].addr !== 32'h204 || log_q[1].core !== 1) begin fails++; $display("FAIL lock_order: n=%0d want two core-1 txns 200,204", log_q.size()); end
        req_lock[1] = 1'b0;
        wait_clear(4'h8, 50, ok);
        checks++; if (!ok || log_q.size() != 3) begin fails++; $display("FAIL lock_release: done=%0b n=%0d want 1 3", ok, log_q.size()); end
        else begin
            checks++; if (log_q[2].core !== 3 || log_q[2].addr !== 32'h300 || locked !== 1'b0) begin fails++; $display("FAIL lock_core3: core=%0d addr=%h locked=%b want 3 300 0", log_q[2].core, log_q[2].addr, locked); end
        end
        log_q.delete();
    endtask

    task automatic test_init_done();
        bit ok;
        init_done = 1'b0;
        slv_dly_min = 1; slv_dly_max = 1;
        set_req(0, 1'b1, 1'b0, 32'h800, 32'h0, 3'd4);
        tick();
        clr_req();
        tick(); tick(); tick();
        checks++; if (m_le !== 1'b0 || core_busy[0] !== 1'b1) begin fails++; $display("FAIL init_hold: m_le=%b busy0=%b want 0 1", m_le, core_busy[0]); end
        init_done = 1'b1;
        tick();
        checks++; if (m_le !== 1'b1 || m_addr !== 32'h800) begin fails++; $display("FAIL init_go: m_le=%b addr=%h want 1 800", m_le, m_addr); end
        init_done = 1'b0;
        wait_clear(4'h1, 50, ok);
        checks++; if (!ok || log_q.size() != 1) begin fails++; $display("FAIL init_midtxn: done=%0b n=%0d want 1 1", ok, log_q.size()); end
        init_done = 1'b1;
        slv_dly_min = 0; slv_dly_max = 0;
        log_q.delete();
    endtask

    task automatic test_errors();
        bit ok;
        set_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 3'd2);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h404, 32'h0, 3'd2);
        tick();
        clr_req();
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_dup: err=%b want 1", err); end
        wait_clear(4'h1, 50, ok);
        repeat (6) tick();
        checks++; if (!ok || log_q.size() != 1 || log_q[0].addr !== 32'h400) begin fails++; $display("FAIL err_drop: done=%0b n=%0d want one txn at 400", ok, log_q.size()); end
        pulse_reset();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear: err=%b want 0", err); end
        set_req(1, 1'b1, 1'b0, 32'h500, 32'h0, 3'd2);
        poke_busy = 1'b1;
        tick();
        clr_req();
        tick();
        checks++; if (err !== 1'b1 || m_le !== 1'b0) begin fails++; $display("FAIL err_idlebusy: err=%b m_le=%b want 1 0", err, m_le); end
        tick();
        checks++; if (m_le !== 1'b0) begin fails++; $display("FAIL err_stayidle: m_le=%b want 0", m_le); end
        poke_busy = 1'b0;
        tick();
        checks++; if (m_le !== 1'b1 || grant !== 2'd1) begin fails++; $display("FAIL err_resume: m_le=%b grant=%0d want 1 1", m_le, grant); end
        wait_clear(4'h2, 50, ok);
        checks++; if (!ok || err !== 1'b1) begin fails++; $display("FAIL err_sticky: done=%0b err=%b want 1 1", ok, err); end
        log_q.delete();
    endtask

    task automatic test_async_reset();
        bit ok;
        slv_bl_min = 8; slv_bl_max = 8;
        set_req(2, 1'b1, 1'b0, 32'h600, 32'h66, 3'd3);
        tick();
        clr_req();
        tick(); tick(); tick();
        checks++; if (m_le !== 1'b0 || core_busy[2] !== 1'b1 || grant !== 2'd2) begin fails++; $display("FAIL ar_wait: m_le=%b busy2=%b grant=%0d want 0 1 2", m_le, core_busy[2], grant); end
        #3 RST_X = 1'b0;
        #1;
        checks++; if (core_busy !== 4'b0 || core_rdata !== '0 || grant !== 2'd0) begin fails++; $display("FAIL ar_core: busy=%b rdata=%h grant=%0d want 0", core_busy, core_rdata, grant); end
        checks++; if ({m_le, m_we, locked, err} !== 4'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0 || m_ctrl !== 3'd0) begin fails++; $display("FAIL ar_bus: flags=%b addr=%h wdata=%h ctrl=%h want 0", {m_le, m_we, locked, err}, m_addr, m_wdata, m_ctrl); end
        @(posedge CLK);
        @(posedge CLK);
        #4 RST_X = 1'b1;
        slv_bl_min = 1; slv_bl_max = 1;
        tick();
        log_q.delete();
        set_req(3, 1'b0, 1'b1, 32'h700, 32'h7777, 3'd5);
        tick();
        clr_req();
        wait_clear(4'h8, 50, ok);
        checks++; if (!ok || log_q.size() != 1) begin fails++; $display("FAIL ar_after: done=%0b n=%0d want 1 1", ok, log_q.size()); end
        else begin
            checks++; if (log_q[0].core !== 3 || log_q[0].addr !== 32'h700 || log_q[0].we !== 1'b1 || core_rdata[3*DW +: DW] !== log_q[0].rd) begin fails++; $display("FAIL ar_txn: core=%0d addr=%h rdata=%h want 3 700 %h", log_q[0].core, log_q[0].addr, core_rdata[3*DW +: DW], log_q[0].rd); end
        end
        checks++; if (core_busy !== 4'b0 || err !== 1'b0) begin fails++; $display("FAIL ar_clean: busy=%b err=%b want 0 0", core_busy, err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_load();
        test_random();
        test_lock();
        test_init_done();
        test_errors();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
